// File: rtl/scr1_tcm_hs_memory.sv
// scr1_tcm_hs_memory: single-port synchronous TCM RAM with byte enables,
// a valid/ready request channel and an in-order, back-pressured response
// channel. A registered array read feeds either straight to the response
// port (bypass) or into a small response buffer when the consumer stalls.
// Optional per-byte even parity is enabled by defining SCR1_TCM_PARITY_EN.
module scr1_tcm_hs_memory #(
  parameter int SCR1_WIDTH  = 32,
  parameter int SCR1_SIZE   = 65536,
  parameter int RESP_DEPTH  = 2,
  parameter int SCR1_NBYTES = SCR1_WIDTH / 8,
  parameter int AW          = $clog2(SCR1_SIZE / SCR1_NBYTES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [SCR1_NBYTES-1:0] req_be,
  input  logic [AW-1:0]          req_addr,
  input  logic [SCR1_WIDTH-1:0]  req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [SCR1_WIDTH-1:0]  resp_rdata,
  output logic                   resp_err
`ifdef SCR1_TCM_PARITY_EN
  ,
  input  logic                   par_inj
`endif
);

  localparam int WORDS = SCR1_SIZE / SCR1_NBYTES;
  localparam int PW    = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW    = $clog2(RESP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RESP_DEPTH - 1);

  // Storage array and its registered read port
  logic [SCR1_WIDTH-1:0] mem [WORDS];
  logic [SCR1_WIDTH-1:0] rdata_arr_q;

  // Single-cycle stage between array read and the response port
  logic s1_valid_q;
  logic s1_we_q;
  logic [SCR1_WIDTH-1:0] s1_rdata;
  logic s1_err;

  // Response buffer
  logic [SCR1_WIDTH-1:0] buf_rdata_q [RESP_DEPTH];
  logic                  buf_err_q   [RESP_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;

  // Outstanding-request accounting
  logic [CW-1:0] occ_q, occ_d;
  logic          req_ready_q;

  // Last presented response, held while the channel is idle
  logic [SCR1_WIDTH-1:0] last_rdata_q;
  logic                  last_err_q;

  logic accept;
  logic buf_empty;
  logic pop;
  logic bypass_pop;
  logic push;
  logic buf_pop;
  logic [SCR1_WIDTH-1:0] cur_rdata;
  logic                  cur_err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign accept     = req_valid & req_ready_q;
  assign buf_empty  = (buf_cnt_q == '0);
  assign resp_valid = s1_valid_q | ~buf_empty;
  assign pop        = resp_valid & resp_ready;
  // The stage entry is always younger than anything buffered, so it may only
  // leave directly when the buffer is empty.
  assign bypass_pop = buf_empty & s1_valid_q & resp_ready;
  assign push       = s1_valid_q & ~bypass_pop;
  assign buf_pop    = ~buf_empty & resp_ready;
  assign req_ready  = req_ready_q;

  assign s1_rdata = s1_we_q ? '0 : rdata_arr_q;

`ifdef SCR1_TCM_PARITY_EN
  logic [SCR1_NBYTES-1:0] mem_par [WORDS];
  logic [SCR1_NBYTES-1:0] rpar_q;
  logic [SCR1_NBYTES-1:0] wpar;
  logic [SCR1_NBYTES-1:0] par_mis;

  for (genvar gi = 0; gi < SCR1_NBYTES; gi++) begin : g_par
    // Even parity per lane; par_inj deliberately corrupts the stored bit
    assign wpar[gi]    = (^req_wdata[gi*8 +: 8]) ^ par_inj;
    assign par_mis[gi] = (^rdata_arr_q[gi*8 +: 8]) ^ rpar_q[gi];
  end

  // Parity array written lane-by-lane alongside the data, read with it
  always_ff @(posedge clk) begin
    if (accept) begin
      if (req_we) begin
        for (int i = 0; i < SCR1_NBYTES; i++) begin
          if (req_be[i]) begin
            mem_par[req_addr][i] <= wpar[i];
          end
        end
      end else begin
        rpar_q <= mem_par[req_addr];
      end
    end
  end

  assign s1_err = ~s1_we_q & (|par_mis);
`else
  assign s1_err = 1'b0;
`endif

  // Array write with byte enables, or registered read, on an accepted request
  always_ff @(posedge clk) begin
    if (accept) begin
      if (req_we) begin
        for (int i = 0; i < SCR1_NBYTES; i++) begin
          if (req_be[i]) begin
            mem[req_addr][i*8 +: 8] <= req_wdata[i*8 +: 8];
          end
        end
      end else begin
        rdata_arr_q <= mem[req_addr];
      end
    end
  end

  // Response mux: buffered head first, otherwise the bypass stage
  always_comb begin
    cur_rdata = s1_rdata;
    cur_err   = s1_err;
    if (!buf_empty) begin
      cur_rdata = buf_rdata_q[rd_ptr_q];
      cur_err   = buf_err_q[rd_ptr_q];
    end
    resp_rdata = last_rdata_q;
    resp_err   = last_err_q;
    if (resp_valid) begin
      resp_rdata = cur_rdata;
      resp_err   = cur_err;
    end
  end

  // Next-state for occupancy and buffer pointers
  always_comb begin
    occ_d = occ_q;
    if (accept && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (!accept && pop) begin
      occ_d = occ_q - 1'b1;
    end
    buf_cnt_d = buf_cnt_q;
    if (push && !buf_pop) begin
      buf_cnt_d = buf_cnt_q + 1'b1;
    end else if (!push && buf_pop) begin
      buf_cnt_d = buf_cnt_q - 1'b1;
    end
    wr_ptr_d = push    ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = buf_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  // Control state; reset drops everything in flight or buffered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_we_q      <= 1'b0;
      occ_q        <= '0;
      buf_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      req_ready_q  <= 1'b0;
      last_rdata_q <= '0;
      last_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= accept;
      if (accept) begin
        s1_we_q <= req_we;
      end
      occ_q       <= occ_d;
      buf_cnt_q   <= buf_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      req_ready_q <= (occ_d < DEPTH_C);
      if (resp_valid) begin
        last_rdata_q <= cur_rdata;
        last_err_q   <= cur_err;
      end
    end
  end

  // Buffer capture of a stage entry that was not consumed directly
  always_ff @(posedge clk) begin
    if (push) begin
      buf_rdata_q[wr_ptr_q] <= s1_rdata;
      buf_err_q[wr_ptr_q]   <= s1_err;
    end
  end

endmodule

// File: tb/tb_scr1_tcm_hs_memory.sv
// Directed table-driven bench for scr1_tcm_hs_memory (default parameters),
// plus hand sequences for random ordering, async reset and parity.
module tb_scr1_tcm_hs_memory;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
`ifdef SCR1_TCM_PARITY_EN
  logic        par_inj;
`endif

  int checks;
  int failures;

  scr1_tcm_hs_memory dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_be     (req_be),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
`ifdef SCR1_TCM_PARITY_EN
    ,
    .par_inj    (par_inj)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v;
    logic        we;
    logic [3:0]  be;
    logic [13:0] addr;
    logic [31:0] wd;
    logic        rr;
    logic        e_rdy;
    logic        e_rv;
    logic [31:0] e_rd;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  function automatic vec_t mk(input logic v, input logic we, input logic [3:0] be,
                              input logic [13:0] addr, input logic [31:0] wd,
                              input logic rr, input logic e_rdy, input logic e_rv,
                              input logic [31:0] e_rd);
    vec_t r;
    r.v = v; r.we = we; r.be = be; r.addr = addr; r.wd = wd; r.rr = rr;
    r.e_rdy = e_rdy; r.e_rv = e_rv; r.e_rd = e_rd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [3:0] be,
                       input logic [13:0] addr, input logic [31:0] wd, input logic rr);
    req_valid = v; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
    resp_ready = rr;
  endtask

  // Advance to the next cycle's sampling point
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] mmem [8];
  logic [31:0] q [$];

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b0);
`ifdef SCR1_TCM_PARITY_EN
    par_inj = 1'b0;
`endif

    //            v  we  be    addr    wdata         rr rdy rv  rdata
    vt[0]  = mk(1, 1, 4'hF, 14'h10, 32'hDEADBEEF, 1, 1, 0, 32'h0);
    vt[1]  = mk(1, 0, 4'h0, 14'h10, 32'h0,        1, 1, 1, 32'h0);
    vt[2]  = mk(1, 1, 4'hF, 14'h20, 32'hDEADBEEF, 1, 1, 1, 32'hDEADBEEF);
    vt[3]  = mk(1, 1, 4'h5, 14'h20, 32'h11223344, 1, 1, 1, 32'h0);
    vt[4]  = mk(1, 0, 4'h0, 14'h20, 32'h0,        1, 1, 1, 32'h0);
    vt[5]  = mk(0, 0, 4'h0, 14'h0,  32'h0,        1, 1, 1, 32'hDE22BE44);
    vt[6]  = mk(0, 0, 4'h0, 14'h0,  32'h0,        1, 1, 0, 32'h0);
    vt[7]  = mk(1, 1, 4'h0, 14'h10, 32'hFFFFFFFF, 1, 1, 0, 32'h0);
    vt[8]  = mk(1, 0, 4'h0, 14'h10, 32'h0,        1, 1, 1, 32'h0);
    vt[9]  = mk(0, 0, 4'h0, 14'h0,  32'h0,        1, 1, 1, 32'hDEADBEEF);
    vt[10] = mk(1, 1, 4'hF, 14'h30, 32'hCAFEF00D, 1, 1, 0, 32'h0);
    vt[11] = mk(0, 0, 4'h0, 14'h0,  32'h0,        1, 1, 1, 32'h0);
    vt[12] = mk(0, 0, 4'h0, 14'h0,  32'h0,        1, 1, 0, 32'h0);
    vt[13] = mk(1, 0, 4'h0, 14'h10, 32'h0,        0, 1, 0, 32'h0);
    vt[14] = mk(1, 0, 4'h0, 14'h20, 32'h0,        0, 1, 1, 32'hDEADBEEF);
    vt[15] = mk(1, 0, 4'h0, 14'h30, 32'h0,        0, 0, 1, 32'hDEADBEEF);
    vt[16] = mk(1, 0, 4'h0, 14'h30, 32'h0,        1, 0, 1, 32'hDEADBEEF);
    vt[17] = mk(1, 0, 4'h0, 14'h30, 32'h0,        0, 1, 1, 32'hDE22BE44);
    vt[18] = mk(0, 0, 4'h0, 14'h0,  32'h0,        0, 0, 1, 32'hDE22BE44);
    vt[19] = mk(0, 0, 4'h0, 14'h0,  32'h0,        1, 0, 1, 32'hDE22BE44);
    vt[20] = mk(0, 0, 4'h0, 14'h0,  32'h0,        1, 1, 1, 32'hCAFEF00D);
    vt[21] = mk(0, 0, 4'h0, 14'h0,  32'h0,        1, 1, 0, 32'h0);
    vt[22] = mk(1, 0, 4'h0, 14'h10, 32'h0,        1, 1, 0, 32'h0);
    vt[23] = mk(1, 0, 4'h0, 14'h20, 32'h0,        1, 1, 1, 32'hDEADBEEF);
    vt[24] = mk(1, 0, 4'h0, 14'h30, 32'h0,        1, 1, 1, 32'hDE22BE44);
    vt[25] = mk(0, 0, 4'h0, 14'h0,  32'h0,        1, 1, 1, 32'hCAFEF00D);
    vt[26] = mk(0, 0, 4'h0, 14'h0,  32'h0,        1, 1, 0, 32'h0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();

    // Directed vectors: each entry is one cycle
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].v, vt[i].we, vt[i].be, vt[i].addr, vt[i].wd, vt[i].rr);
      #1;
      $display("vec %0d: v=%0b we=%0b addr=%h rr=%0b -> rdy=%0b rv=%0b rdata=%h",
               i, vt[i].v, vt[i].we, vt[i].addr, vt[i].rr, req_ready, resp_valid, resp_rdata);
      chk($sformatf("vec%0d_req_ready", i), {31'b0, req_ready}, {31'b0, vt[i].e_rdy});
      chk($sformatf("vec%0d_resp_valid", i), {31'b0, resp_valid}, {31'b0, vt[i].e_rv});
      if (vt[i].e_rv) begin
        chk($sformatf("vec%0d_resp_rdata", i), resp_rdata, vt[i].e_rd);
        chk($sformatf("vec%0d_resp_err", i), {31'b0, resp_err}, 32'h0);
      end
      next_cyc();
    end

    // Random traffic against a queue reference model (word addresses 0..7)
    q.delete();
    for (int i = 0; i < 100; i++) begin
      logic v, we, rr, acc, pp;
      logic [3:0] be;
      logic [13:0] addr;
      logic [31:0] wd;
      v  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      addr = 14'($urandom_range(0, 7));
      wd = $urandom;
      if (i < 8) begin
        v = 1'b1; we = 1'b1; be = 4'hF; addr = 14'(i); rr = 1'b1;
      end
      drive(v, we, be, addr, wd, rr);
      #1;
      chk($sformatf("rnd%0d_req_ready", i), {31'b0, req_ready}, {31'b0, (q.size() < 2)});
      chk($sformatf("rnd%0d_resp_valid", i), {31'b0, resp_valid}, {31'b0, (q.size() != 0)});
      if (q.size() != 0) begin
        chk($sformatf("rnd%0d_resp_rdata", i), resp_rdata, q[0]);
      end
      acc = v && (q.size() < 2);
      pp  = (q.size() != 0) && rr;
      if (pp) void'(q.pop_front());
      if (acc) begin
        if (we) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) mmem[addr[2:0]][b*8 +: 8] = wd[b*8 +: 8];
          end
          q.push_back(32'h0);
        end else begin
          q.push_back(mmem[addr[2:0]]);
        end
      end
      next_cyc();
    end

    // Drain, then async reset with two responses buffered
    drive(1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1);
    repeat (3) next_cyc();
    drive(1'b1, 1'b0, 4'h0, 14'h10, 32'h0, 1'b0);
    next_cyc();
    drive(1'b1, 1'b0, 4'h0, 14'h20, 32'h0, 1'b0);
    next_cyc();
    drive(1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b0);
    #1;
    chk("pre_rst_resp_valid", {31'b0, resp_valid}, 32'h1);
    chk("pre_rst_resp_rdata", resp_rdata, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("async_rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("async_rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("async_rst_resp_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("post_rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 14'h30, 32'h0, 1'b1);
    next_cyc();
    drive(1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1);
    #1;
    chk("post_rst_read_valid", {31'b0, resp_valid}, 32'h1);
    chk("post_rst_read_rdata", resp_rdata, 32'hCAFEF00D);
    next_cyc();

`ifdef SCR1_TCM_PARITY_EN
    // Parity: full clean write, then corrupt lanes 0/1, then repair
    drive(1'b1, 1'b1, 4'hF, 14'h40, 32'hA5A5A5A5, 1'b1);
    next_cyc();
    drive(1'b1, 1'b1, 4'h3, 14'h40, 32'hA5A5A5A5, 1'b1);
    par_inj = 1'b1;
    next_cyc();
    par_inj = 1'b0;
    drive(1'b1, 1'b0, 4'h0, 14'h40, 32'h0, 1'b1);
    #1;
    chk("par_wr_resp_err", {31'b0, resp_err}, 32'h0);
    next_cyc();
    drive(1'b1, 1'b1, 4'h3, 14'h40, 32'hA5A5A5A5, 1'b1);
    #1;
    chk("par_bad_rdata", resp_rdata, 32'hA5A5A5A5);
    chk("par_bad_err", {31'b0, resp_err}, 32'h1);
    next_cyc();
    drive(1'b1, 1'b0, 4'h0, 14'h40, 32'h0, 1'b1);
    next_cyc();
    drive(1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1);
    #1;
    chk("par_good_valid", {31'b0, resp_valid}, 32'h1);
    chk("par_good_err", {31'b0, resp_err}, 32'h0);
    next_cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scr1_tcm_hs_memory.md
Name: scr1_tcm_hs_memory

Overview:
Parametrised single-port synchronous TCM memory with byte enables, for the SCR1 TCM path. Successor to the bare rena/wena macro: adds a valid/ready request channel, an in-order response channel with back-pressure, and a response buffer. Every accepted request produces exactly one response. Sits between the TCM router and the RAM array, so the router no longer tracks read latency itself.

Parameters:
SCR1_WIDTH, 32, data width in bits; multiple of 8, >= 8
SCR1_SIZE, 65536, memory size in bytes; power of two
RESP_DEPTH, 2, response buffer entries (1..4); caps outstanding requests
SCR1_NBYTES, SCR1_WIDTH/8, derived; byte lanes
AW, $clog2(SCR1_SIZE/SCR1_NBYTES), derived; word address width

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_we  in  1  1 = write, 0 = read
req_be  in  SCR1_NBYTES  write byte enables; ignored on reads
req_addr  in  AW  word address
req_wdata  in  SCR1_WIDTH  write data
resp_valid  out  1  response available
resp_ready  in  1  response consumed when resp_valid & resp_ready
resp_rdata  out  SCR1_WIDTH  read data; 0 for write responses
resp_err  out  1  response error flag; 0 when the optional feature is out
par_inj  in  1  present only with the optional feature; see below

Behaviour:
- Reset (rst_n low, async): req_ready=0 while rst_n is low; resp_valid=0, resp_rdata=0, resp_err=0. Occupancy counter, buffer pointers and the in-flight flag are cleared. Array contents are not reset.
- Reset mid-operation: in-flight and buffered responses are dropped. req_ready=1 in the first cycle after rst_n deasserts.
- Occupancy counter occ (0..RESP_DEPTH):
  - +1 on accept, -1 on response pop, unchanged when both happen in one cycle.
  - req_ready = (occ < RESP_DEPTH), registered-path only. There is no combinational path from resp_ready or req_valid to req_ready.
- Write accepted at cycle T: lanes with req_be[i]=1 are written at the end of T. A write response (rdata=0, err=0) is eligible from T+1.
- Read accepted at cycle T: the array is read at the end of T. Data is eligible as a response from T+1.
- Read-after-write: a read accepted at T+1 to the address written at T returns the new data.
- Same-cycle read and write cannot occur; one request per cycle.
- Response path:
  - Buffer empty and no earlier response pending: the array output bypasses the buffer, so resp_valid=1 in T+1 (1-cycle latency).
  - Not popped in T+1: the entry is captured into the buffer and the held data stays stable until popped.
  - While resp_valid=1 and resp_ready=0, resp_rdata and resp_err must not change.
- Ordering: responses are returned strictly in acceptance order.
- Full: at occ==RESP_DEPTH, req_ready=0. A pop in cycle C raises req_ready in C+1.
- Empty: resp_valid=0. resp_rdata holds its last value and is don't-care to consumers.
- Pointers wrap modulo RESP_DEPTH; RESP_DEPTH=1 must work.
- req_be=0 on a write: no array change, response still generated.

Optional Feature:
Macro SCR1_TCM_PARITY_EN.
- Defined:
  - Array stores one even-parity bit per byte lane, written together with the data byte.
  - On read, per-lane parity is recomputed. resp_err=1 if any lane mismatches; data is returned unchanged.
  - Port par_inj exists: when 1 on an accepted write, the stored parity of every enabled lane is inverted.
  - Write responses always have err=0.
- Not defined: no parity storage, no par_inj port, resp_err tied 0.

Test Plan:
- Reset, then write addr 0x10 data 0xDEADBEEF be=0xF; read 0x10 next cycle with resp_ready=1 -> write resp (rdata 0) at T+1, read resp rdata=0xDEADBEEF at T+2, resp_err=0.
- Partial write be=0x5 data 0x11223344 over 0xDEADBEEF at 0x20, then read 0x20 -> rdata=0xDE22BE44.
- resp_ready=0, RESP_DEPTH=2: issue 3 back-to-back reads -> 2 accepted, req_ready=0 from next cycle. Raise resp_ready -> responses in order with stable data while stalled; third request accepted one cycle after the first pop.
- Simultaneous accept and pop at occ=1 -> occ stays 1, req_ready stays 1, no response lost or duplicated over 100 random cycles against a reference model.
- Assert rst_n low with 2 responses buffered -> resp_valid=0 immediately (async). After release, the next read returns array data written before reset.
- SCR1_TCM_PARITY_EN: write 0xA5A5A5A5 be=0x3 with par_inj=1, read back -> rdata=0xA5A5A5A5, resp_err=1. Rewrite with par_inj=0, read -> resp_err=0.
